// File: rtl/writeback_seq_if.sv
// writeback_seq_if: ALU/load/jal sources and register-file write port of writeback_seq
interface writeback_seq_if #(parameter int DATA_WIDTH = 32);
  logic                  alu_valid;
  logic                  alu_ready;
  logic [4:0]            alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  ld_valid;
  logic                  ld_ready;
  logic [4:0]            ld_rd;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  jal;
  logic [DATA_WIDTH-1:0] PC;
  logic                  regWrite;
  logic [4:0]            writeRegister;
  logic [DATA_WIDTH-1:0] writeData;
  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, jal, PC,
    input  alu_ready, ld_ready, regWrite, writeRegister, writeData
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, jal, PC,
    output alu_ready, ld_ready, regWrite, writeRegister, writeData
  );
endinterface

// File: rtl/writeback_seq.sv
// writeback_seq: merges jal link, load and queued/bypassed ALU writes onto one register-file port
module writeback_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  writeback_seq_if.slave                wb,
  output logic [31:0]                   pending_mask,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [PW-1:0]           head_q, head_d, tail_q, tail_d, off;
  logic [PW:0]             count_q, count_d;
  logic [4:0]              rd_q [FIFO_DEPTH];
  logic [4:0]              rd_d [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   data_d [FIFO_DEPTH];
  logic                    reg_write_q, reg_write_d;
  logic [4:0]              write_register_q, write_register_d;
  logic [DATA_WIDTH-1:0]   write_data_q, write_data_d;
  logic                    alu_acc, ld_acc, pop, push, sel_valid;
  logic [4:0]              sel_rd;
  logic [DATA_WIDTH-1:0]   sel_data;
  assign wb.alu_ready     = count_q < (PW+1)'(FIFO_DEPTH);
  assign wb.ld_ready      = !wb.jal;
  assign wb.regWrite      = reg_write_q;
  assign wb.writeRegister = write_register_q;
  assign wb.writeData     = write_data_q;
  assign fifo_count       = count_q;
  // Fixed-priority source pick: jal, load, queue head, then ALU bypass; queue only drains when jal and load are idle
  always_comb begin
    alu_acc   = wb.alu_valid & wb.alu_ready;
    ld_acc    = wb.ld_valid & wb.ld_ready;
    pop       = !wb.jal & !ld_acc & (|count_q);
    push      = alu_acc & (wb.jal | ld_acc | (|count_q));
    sel_valid = wb.jal | ld_acc | pop | alu_acc;
    sel_rd    = wb.jal ? 5'd31 : ld_acc ? wb.ld_rd : pop ? rd_q[head_q] : wb.alu_rd;
    sel_data  = wb.jal ? wb.PC + {{(DATA_WIDTH-1){1'b0}}, 1'b1} :
                ld_acc ? wb.ld_data : pop ? data_q[head_q] : wb.alu_data;
    reg_write_d      = sel_valid & (|sel_rd);
    write_register_d = reg_write_d ? sel_rd : write_register_q;
    write_data_d     = reg_write_d ? sel_data : write_data_q;
  end
  // Queue pointers and storage; power-of-two depth makes pointer wrap free
  always_comb begin
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(push);
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    rd_d    = rd_q;
    data_d  = data_q;
    if (push) begin
      rd_d[tail_q]   = wb.alu_rd;
      data_d[tail_q] = wb.alu_data;
    end
  end
  // Scoreboard of registers with a queued write still outstanding; r0 is never a real hazard
  always_comb begin
    pending_mask = '0;
    off          = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      off = PW'(i) - head_q;
      if ({1'b0, off} < count_q) pending_mask[rd_q[i]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end
  // Control state with synchronous reset discarding any queued entries
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      reg_write_q      <= 1'b0;
      write_register_q <= '0;
      write_data_q     <= '0;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      reg_write_q      <= reg_write_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
    end
  end
  // Entry payloads need no reset; validity comes from the pointers
  always_ff @(posedge clk) begin
    rd_q   <= rd_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_writeback_seq.sv
// tb_writeback_seq: directed stimulus with a queue-based reference model of writeback_seq
module tb_writeback_seq;
  localparam int DW = 32, D = 4;
  logic clk = 0;
  logic reset;
  logic [31:0] pending_mask;
  logic [2:0]  fifo_count;
  int checks = 0, errors = 0;
  bit go = 0;
  typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;
  ent_t mq[$];
  logic e_wr = 0;
  logic [4:0] e_reg = 0;
  logic [31:0] e_data = 0;
  always #5 clk = ~clk;
  writeback_seq_if #(.DATA_WIDTH(DW)) wb();
  writeback_seq #(.DATA_WIDTH(DW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .wb(wb), .pending_mask(pending_mask), .fifo_count(fifo_count)
  );
  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask
  function automatic logic [31:0] exp_mask();
    logic [31:0] m = '0;
    foreach (mq[i]) m[mq[i].rd] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction
  task automatic model_step();
    bit aacc, lacc, sv;
    ent_t e;
    logic [4:0] r;
    logic [31:0] d;
    if (reset) begin
      mq.delete();
      e_wr = 0; e_reg = 0; e_data = 0;
      return;
    end
    aacc = wb.alu_valid && mq.size() < D;
    lacc = wb.ld_valid && !wb.jal;
    sv = 1; r = 0; d = 0;
    if (wb.jal) begin r = 31; d = wb.PC + 1; end
    else if (lacc) begin r = wb.ld_rd; d = wb.ld_data; end
    else if (mq.size() > 0) begin e = mq.pop_front(); r = e.rd; d = e.d; end
    else if (aacc) begin r = wb.alu_rd; d = wb.alu_data; aacc = 0; end
    else sv = 0;
    if (aacc) mq.push_back('{wb.alu_rd, wb.alu_data});
    e_wr = sv && r != 0;
    if (e_wr) begin e_reg = r; e_data = d; end
  endtask
  initial forever begin
    @(posedge clk);
    model_step();
  end
  initial forever begin
    @(negedge clk);
    if (go) begin
      chk("regWrite", wb.regWrite, e_wr);
      chk("writeRegister", wb.writeRegister, e_reg);
      chk("writeData", wb.writeData, e_data);
      chk("fifo_count", fifo_count, mq.size());
      chk("pending_mask", pending_mask, exp_mask());
      chk("alu_ready", wb.alu_ready, mq.size() < D);
      chk("ld_ready", wb.ld_ready, !wb.jal);
    end
  end
  task automatic idle();
    wb.alu_valid = 0; wb.alu_rd = 0; wb.alu_data = 0;
    wb.ld_valid = 0; wb.ld_rd = 0; wb.ld_data = 0;
    wb.jal = 0; wb.PC = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic alu(input logic [4:0] r, input logic [31:0] d);
    wb.alu_valid = 1; wb.alu_rd = r; wb.alu_data = d;
  endtask
  initial begin
    int ai;
    bit acc;
    reset = 1;
    idle();
    tick(); tick();
    reset = 0;
    go = 1;
    chk("rst_regWrite", wb.regWrite, 0);
    chk("rst_writeRegister", wb.writeRegister, 0);
    chk("rst_writeData", wb.writeData, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_pending", pending_mask, 0);
    alu(5, 32'h1234);
    tick(); idle();
    chk("byp_regWrite", wb.regWrite, 1);
    chk("byp_reg", wb.writeRegister, 5);
    chk("byp_data", wb.writeData, 32'h1234);
    chk("byp_fifo", fifo_count, 0);
    wb.jal = 1; wb.PC = 32'h40;
    wb.ld_valid = 1; wb.ld_rd = 7; wb.ld_data = 32'h77;
    alu(8, 32'h88);
    #1 chk("jal_ld_ready", wb.ld_ready, 0);
    tick(); idle();
    chk("jal_reg", wb.writeRegister, 31);
    chk("jal_data", wb.writeData, 32'h41);
    chk("jal_fifo", fifo_count, 1);
    chk("jal_pending", pending_mask, 32'h100);
    tick();
    chk("drain_reg", wb.writeRegister, 8);
    chk("drain_data", wb.writeData, 32'h88);
    chk("drain_fifo", fifo_count, 0);
    wb.jal = 1; wb.PC = 32'hFFFF_FFFF;
    tick(); idle();
    chk("wrap_regWrite", wb.regWrite, 1);
    chk("wrap_reg", wb.writeRegister, 31);
    chk("wrap_data", wb.writeData, 0);
    alu(0, 32'hFFFF_FFFF);
    tick(); idle();
    chk("r0_regWrite", wb.regWrite, 0);
    chk("r0_data_hold", wb.writeData, 0);
    chk("r0_reg_hold", wb.writeRegister, 31);
    chk("r0_fifo", fifo_count, 0);
    ai = 0;
    for (int c = 0; c < 6; c++) begin
      wb.ld_valid = 1; wb.ld_rd = 5'(10 + c); wb.ld_data = 32'h100 + c;
      alu(5'(20 + ai), 32'h200 + ai);
      acc = wb.alu_ready;
      if (c == 4) chk("full_alu_ready", acc, 0);
      tick();
      chk("ld_reg", wb.writeRegister, 10 + c);
      chk("ld_data", wb.writeData, 32'h100 + c);
      if (acc) ai++;
    end
    idle();
    chk("stream_fifo_full", fifo_count, 4);
    chk("stream_pending", pending_mask, 32'h00F0_0000);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("q_reg", wb.writeRegister, 20 + k);
      chk("q_data", wb.writeData, 32'h200 + k);
    end
    chk("stream_fifo_empty", fifo_count, 0);
    for (int k = 0; k < 2; k++) begin
      wb.jal = 1; wb.PC = 32'h80 + k;
      alu(5'(12 + k), 32'h300 + k);
      tick();
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      alu(5'(14 + k), 32'h400 + k);
      tick();
      chk("pp_reg", wb.writeRegister, 12 + k);
      chk("pp_fifo", fifo_count, 2);
    end
    idle();
    tick(); tick(); tick();
    chk("pp_drained", fifo_count, 0);
    for (int k = 0; k < 3; k++) begin
      wb.jal = 1; wb.PC = k;
      alu(5'(1 + k), 32'h500 + k);
      tick();
    end
    idle();
    chk("pre_rst_fifo", fifo_count, 3);
    chk("pre_rst_pending", pending_mask, 32'hE);
    reset = 1;
    alu(9, 32'h999);
    tick();
    reset = 0;
    idle();
    chk("post_rst_fifo", fifo_count, 0);
    chk("post_rst_pending", pending_mask, 0);
    chk("post_rst_regWrite", wb.regWrite, 0);
    chk("post_rst_reg", wb.writeRegister, 0);
    chk("post_rst_data", wb.writeData, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_quiet", wb.regWrite, 0);
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
